pipeline_hazard_ctrl: RTL and testbench

//   Generates the per-stage stall and flush controls consumed by the 7-slot pipeline
//   (pc, sub_if, if, id, ex, sub_mem, mem).

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 38 +++
 rtl/pipeline_hazard_ctrl_if.sv | 55 +++++
 rtl/hazard_load_use_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_STAGES = 7;
    localparam int unsigned HOLD_W     = 3;
    localparam int unsigned WAIT_W     = 8;

    // Stage positions along the pipeline, oldest fetch slot first
    localparam int unsigned STG_PC      = 0;
    localparam int unsigned STG_SUB_IF  = 1;
    localparam int unsigned STG_IF      = 2;
    localparam int unsigned STG_ID      = 3;
    localparam int unsigned STG_EX      = 4;
    localparam int unsigned STG_SUB_MEM = 5;
    localparam int unsigned STG_MEM     = 6;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_REDIRECT  = 2'd1,
        ST_DMEM_WAIT = 2'd2
    } state_t;

    typedef logic [NUM_STAGES-1:0] stage_vec_t;

    // Mask with every stage from lo to hi (inclusive) set
    function automatic stage_vec_t stage_range(input int unsigned lo, input int unsigned hi);
        stage_vec_t m;
        m = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (i >= lo && i <= hi) begin
                m[3'(i)] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side hazard inputs and per-stage stall/flush controls.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
) ();
    import pipeline_hazard_ctrl_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic                  ex_valid;
    logic                  ex_is_load;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_redirect;
    logic                  imem_ready;
    logic                  dmem_req;
    logic                  dmem_ready;

    logic                  stall_pc;
    logic                  stall_sub_if;
    logic                  stall_if;
    logic                  stall_id;
    logic                  stall_ex;
    logic                  stall_sub_mem;
    logic                  flush_sub_if;
    logic                  flush_if;
    logic                  flush_id;
    logic                  flush_ex;
    logic                  flush_sub_mem;
    logic                  flush_mem;
    logic                  mem_err;
    logic [CNT_W-1:0]      stall_cycles;

    // Pipeline side: reports hazards, consumes controls
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_valid, ex_is_load, ex_rd, ex_redirect,
        output imem_ready, dmem_req, dmem_ready,
        input  stall_pc, stall_sub_if, stall_if, stall_id, stall_ex, stall_sub_mem,
        input  flush_sub_if, flush_if, flush_id, flush_ex, flush_sub_mem, flush_mem,
        input  mem_err, stall_cycles
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_valid, ex_is_load, ex_rd, ex_redirect,
        input  imem_ready, dmem_req, dmem_ready,
        output stall_pc, stall_sub_if, stall_if, stall_id, stall_ex, stall_sub_mem,
        output flush_sub_if, flush_if, flush_id, flush_ex, flush_sub_mem, flush_mem,
        output mem_err, stall_cycles
    );

endinterface

// File: rtl/hazard_load_use_detect.sv
// Combinational load-use detector: EX load writes a register ID reads.
module hazard_load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_rs1_used,
    input  logic                  i_id_rs2_used,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_is_load,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    output logic                  o_lu_hit
);

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_ex_load_wr;

    // x0 is never written, so a load to x0 cannot create a dependency
    assign w_ex_load_wr = i_ex_valid & i_ex_is_load & (i_ex_rd != '0);
    assign w_rs1_match  = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
    assign w_rs2_match  = i_id_rs2_used & (i_id_rs2 == i_ex_rd);
    assign o_lu_hit     = i_id_valid & w_ex_load_wr & (w_rs1_match | w_rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Per-stage stall/flush generation for the 7-slot pipeline, with redirect and
// data-memory wait sequencing and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REDIRECT_HOLD = 1,
    parameter int unsigned MEM_TIMEOUT   = 255,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam stage_vec_t STALL_DMEM  = stage_range(STG_PC, STG_SUB_MEM);
    localparam stage_vec_t STALL_TMO   = stage_range(STG_PC, STG_EX);
    localparam stage_vec_t STALL_LU    = stage_range(STG_PC, STG_ID);
    localparam stage_vec_t STALL_IMEM  = stage_range(STG_PC, STG_SUB_IF);
    localparam stage_vec_t FLUSH_ALL   = stage_range(STG_SUB_IF, STG_MEM);
    localparam stage_vec_t FLUSH_REDIR = stage_range(STG_SUB_IF, STG_EX);
    localparam stage_vec_t FLUSH_FETCH = stage_range(STG_SUB_IF, STG_IF);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [WAIT_W-1:0]   w_wait_num;
    logic [CNT_W-1:0]    r_stall_cycles;

    logic                w_lu_hit;
    logic                w_dmem_wait;
    logic                w_redirect;
    stage_vec_t          w_stall;
    stage_vec_t          w_flush;
    logic                w_mem_err;

    hazard_load_use_detect u_lu_detect (
        .i_id_valid    (hz.id_valid),
        .i_id_rs1      (hz.id_rs1),
        .i_id_rs2      (hz.id_rs2),
        .i_id_rs1_used (hz.id_rs1_used),
        .i_id_rs2_used (hz.id_rs2_used),
        .i_ex_valid    (hz.ex_valid),
        .i_ex_is_load  (hz.ex_is_load),
        .i_ex_rd       (hz.ex_rd),
        .o_lu_hit      (w_lu_hit)
    );

    assign w_dmem_wait = hz.dmem_req & ~hz.dmem_ready;
    assign w_redirect  = hz.ex_redirect & hz.ex_valid;
    // Ordinal of the current wait cycle; the entry cycle is wait 1
    assign w_wait_num  = (r_state == ST_DMEM_WAIT) ? (r_wait_cnt + WAIT_W'(1)) : WAIT_W'(1);

    // Next-state and output decode; priority dmem wait > redirect > imem wait > load-use
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_stall     = '0;
        w_flush     = '0;
        w_mem_err   = 1'b0;

        if (!rst) begin
            w_flush     = FLUSH_ALL;
            w_state_nxt = ST_RUN;
            w_hold_nxt  = '0;
            w_wait_nxt  = '0;
        end else if (w_dmem_wait) begin
            // Any pending redirect hold is dropped; the held ex_redirect re-arms it on exit
            w_hold_nxt = '0;
            w_flush[STG_MEM] = 1'b1;
            if (w_wait_num == WAIT_W'(MEM_TIMEOUT)) begin
                // Abort: bubble the stuck access out of sub_mem instead of holding it
                w_stall     = STALL_TMO;
                w_flush[STG_SUB_MEM] = 1'b1;
                w_mem_err   = 1'b1;
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end else begin
                w_stall     = STALL_DMEM;
                w_state_nxt = ST_DMEM_WAIT;
                w_wait_nxt  = w_wait_num;
            end
        end else if (w_redirect) begin
            // Also reached on the DMEM_WAIT exit cycle, which behaves as RUN
            w_flush     = FLUSH_REDIR;
            w_hold_nxt  = HOLD_W'(REDIRECT_HOLD);
            w_state_nxt = (REDIRECT_HOLD != 0) ? ST_REDIRECT : ST_RUN;
            w_wait_nxt  = '0;
        end else begin
            w_wait_nxt = '0;
            case (r_state)
                ST_REDIRECT: begin
                    w_flush     = FLUSH_FETCH;
                    w_hold_nxt  = r_hold_cnt - HOLD_W'(1);
                    w_state_nxt = (r_hold_cnt <= HOLD_W'(1)) ? ST_RUN : ST_REDIRECT;
                    // Fetch slots are already being flushed, so only pc and id hold
                    if (w_lu_hit) begin
                        w_stall[STG_PC] = 1'b1;
                        w_stall[STG_ID] = 1'b1;
                        w_flush[STG_EX] = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    if (!hz.imem_ready) begin
                        w_stall = STALL_IMEM;
                        w_flush[STG_IF] = 1'b1;
                    end else if (w_lu_hit) begin
                        w_stall = STALL_LU;
                        w_flush[STG_EX] = 1'b1;
                    end
                end
            endcase
        end
    end

    // State, sequencing counters and saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_RUN;
            r_hold_cnt     <= '0;
            r_wait_cnt     <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_stall[STG_PC] && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

    // A stage must never be told to hold and to bubble in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            assert ((w_stall & w_flush) == '0);
        end
    end

    assign hz.stall_pc      = w_stall[STG_PC];
    assign hz.stall_sub_if  = w_stall[STG_SUB_IF];
    assign hz.stall_if      = w_stall[STG_IF];
    assign hz.stall_id      = w_stall[STG_ID];
    assign hz.stall_ex      = w_stall[STG_EX];
    assign hz.stall_sub_mem = w_stall[STG_SUB_MEM];
    assign hz.flush_sub_if  = w_flush[STG_SUB_IF];
    assign hz.flush_if      = w_flush[STG_IF];
    assign hz.flush_id      = w_flush[STG_ID];
    assign hz.flush_ex      = w_flush[STG_EX];
    assign hz.flush_sub_mem = w_flush[STG_SUB_MEM];
    assign hz.flush_mem     = w_flush[STG_MEM];
    assign hz.mem_err       = w_mem_err;
    assign hz.stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controllers (default timeout, and MEM_TIMEOUT=3 with
// an 8-bit counter) share stimulus; a negedge monitor checks queued expectations.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       id_valid;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_rs1_used;
        logic       id_rs2_used;
        logic       ex_valid;
        logic       ex_is_load;
        logic [4:0] ex_rd;
        logic       ex_redirect;
        logic       imem_ready;
        logic       dmem_req;
        logic       dmem_ready;
    } in_t;

    typedef struct {
        int         cyc;
        bit         sel_b;
        string      nm;
        logic [12:0] outs;
        int         cnt;
    } exp_t;

    // {stall pc,sub_if,if,id,ex,sub_mem}, {flush sub_if,if,id,ex,sub_mem,mem}, mem_err
    localparam logic [12:0] O_NONE = {6'b000000, 6'b000000, 1'b0};
    localparam logic [12:0] O_LU   = {6'b111100, 6'b000100, 1'b0};
    localparam logic [12:0] O_RED0 = {6'b000000, 6'b111100, 1'b0};
    localparam logic [12:0] O_RED1 = {6'b000000, 6'b110000, 1'b0};
    localparam logic [12:0] O_DMEM = {6'b111111, 6'b000001, 1'b0};
    localparam logic [12:0] O_TMO  = {6'b111110, 6'b000011, 1'b1};
    localparam logic [12:0] O_IMEM = {6'b110000, 6'b010000, 1'b0};
    localparam logic [12:0] O_RST  = {6'b000000, 6'b111111, 1'b0};

    localparam in_t IDLE = '{id_valid: 1'b0, id_rs1: 5'd0, id_rs2: 5'd0, id_rs1_used: 1'b0,
                             id_rs2_used: 1'b0, ex_valid: 1'b0, ex_is_load: 1'b0, ex_rd: 5'd0,
                             ex_redirect: 1'b0, imem_ready: 1'b1, dmem_req: 1'b0, dmem_ready: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) hz_a ();
    pipeline_hazard_ctrl_if #(.CNT_W(8))  hz_b ();

    pipeline_hazard_ctrl #(.REDIRECT_HOLD(1), .MEM_TIMEOUT(255), .CNT_W(32)) dut_a (
        .clk (clk),
        .rst (rst),
        .hz  (hz_a)
    );

    pipeline_hazard_ctrl #(.REDIRECT_HOLD(1), .MEM_TIMEOUT(3), .CNT_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .hz  (hz_b)
    );

    logic [12:0] act_a;
    logic [12:0] act_b;
    assign act_a = {hz_a.stall_pc, hz_a.stall_sub_if, hz_a.stall_if, hz_a.stall_id, hz_a.stall_ex,
                    hz_a.stall_sub_mem, hz_a.flush_sub_if, hz_a.flush_if, hz_a.flush_id,
                    hz_a.flush_ex, hz_a.flush_sub_mem, hz_a.flush_mem, hz_a.mem_err};
    assign act_b = {hz_b.stall_pc, hz_b.stall_sub_if, hz_b.stall_if, hz_b.stall_id, hz_b.stall_ex,
                    hz_b.stall_sub_mem, hz_b.flush_sub_if, hz_b.flush_if, hz_b.flush_id,
                    hz_b.flush_ex, hz_b.flush_sub_mem, hz_b.flush_mem, hz_b.mem_err};

    task automatic drive(input in_t v);
        hz_a.id_valid = v.id_valid;       hz_b.id_valid = v.id_valid;
        hz_a.id_rs1 = v.id_rs1;           hz_b.id_rs1 = v.id_rs1;
        hz_a.id_rs2 = v.id_rs2;           hz_b.id_rs2 = v.id_rs2;
        hz_a.id_rs1_used = v.id_rs1_used; hz_b.id_rs1_used = v.id_rs1_used;
        hz_a.id_rs2_used = v.id_rs2_used; hz_b.id_rs2_used = v.id_rs2_used;
        hz_a.ex_valid = v.ex_valid;       hz_b.ex_valid = v.ex_valid;
        hz_a.ex_is_load = v.ex_is_load;   hz_b.ex_is_load = v.ex_is_load;
        hz_a.ex_rd = v.ex_rd;             hz_b.ex_rd = v.ex_rd;
        hz_a.ex_redirect = v.ex_redirect; hz_b.ex_redirect = v.ex_redirect;
        hz_a.imem_ready = v.imem_ready;   hz_b.imem_ready = v.imem_ready;
        hz_a.dmem_req = v.dmem_req;       hz_b.dmem_req = v.dmem_req;
        hz_a.dmem_ready = v.dmem_ready;   hz_b.dmem_ready = v.dmem_ready;
    endtask

    function automatic in_t lu_in(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic u1, input logic u2,
                                  input logic [4:0] rd, input logic is_load);
        in_t v;
        v = IDLE;
        v.id_valid = 1'b1;   v.id_rs1 = rs1;   v.id_rs2 = rs2;
        v.id_rs1_used = u1;  v.id_rs2_used = u2;
        v.ex_valid = 1'b1;   v.ex_is_load = is_load;  v.ex_rd = rd;
        return v;
    endfunction

    function automatic in_t red_in(input logic valid);
        in_t v;
        v = IDLE;
        v.ex_redirect = 1'b1;
        v.ex_valid = valid;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cnt < 0 means the stall counter is not checked for this entry
    task automatic exp_push(input bit sel_b, input string nm, input logic [12:0] o, input int cnt);
        exp_t e;
        e.cyc = cyc; e.sel_b = sel_b; e.nm = nm; e.outs = o; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic exp_both(input string nm, input logic [12:0] o, input int cnt);
        exp_push(1'b0, nm, o, cnt);
        exp_push(1'b1, nm, o, cnt);
    endtask

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [12:0] got;
        int          got_cnt;
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            got     = e.sel_b ? act_b : act_a;
            got_cnt = e.sel_b ? int'(hz_b.stall_cycles) : int'(hz_a.stall_cycles);
            n_total++;
            if (e.cyc != cyc) begin
                $display("FAIL %s dut_%s: expectation for cycle %0d not sampled (now %0d)",
                         e.nm, e.sel_b ? "b" : "a", e.cyc, cyc);
            end else if (got !== e.outs) begin
                $display("FAIL %s dut_%s cyc %0d: controls got %b want %b",
                         e.nm, e.sel_b ? "b" : "a", cyc, got, e.outs);
            end else begin
                n_pass++;
            end
            if (e.cnt >= 0) begin
                n_total++;
                if (got_cnt != e.cnt) begin
                    $display("FAIL %s_cnt dut_%s cyc %0d: stall_cycles got %0d want %0d",
                             e.nm, e.sel_b ? "b" : "a", cyc, got_cnt, e.cnt);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        in_t         v;
        logic [12:0] b_seq [4];
        b_seq = '{O_DMEM, O_DMEM, O_TMO, O_DMEM};

        rst = 1'b0;
        drive(IDLE);
        tick(); drive(IDLE); exp_both("rst_outputs", O_RST, -1);
        tick(); rst = 1'b1; drive(IDLE); exp_both("rst_release", O_NONE, 0);

        // Load-use detection
        tick(); drive(lu_in(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1)); exp_both("lu_rs1", O_LU, -1);
        tick(); drive(IDLE);                                      exp_both("lu_one_cycle", O_NONE, 1);
        tick(); drive(lu_in(5'd0, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1)); exp_both("lu_rd_x0", O_NONE, -1);
        tick(); drive(lu_in(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1)); exp_both("lu_rs2", O_LU, -1);
        tick(); drive(lu_in(5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1)); exp_both("lu_rs2_unused", O_NONE, -1);
        tick(); drive(lu_in(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0)); exp_both("lu_not_load", O_NONE, -1);

        // Imem wait outranks load-use
        tick(); v = lu_in(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1); v.imem_ready = 1'b0; drive(v);
        exp_both("imem_over_lu", O_IMEM, -1);
        tick(); drive(IDLE); exp_both("imem_done", O_NONE, 3);

        // Redirect with one hold cycle, invalid redirect, and restart while holding
        tick(); drive(red_in(1'b1)); exp_both("redir_c0", O_RED0, -1);
        tick(); drive(IDLE);         exp_both("redir_c1", O_RED1, -1);
        tick(); drive(IDLE);         exp_both("redir_c2", O_NONE, -1);
        tick(); drive(red_in(1'b0)); exp_both("redir_invalid", O_NONE, -1);
        tick(); drive(red_in(1'b1)); exp_both("restart_c0", O_RED0, -1);
        tick(); drive(red_in(1'b1)); exp_both("restart_again", O_RED0, -1);
        tick(); drive(IDLE);         exp_both("restart_hold", O_RED1, -1);
        tick(); drive(IDLE);         exp_both("restart_end", O_NONE, 3);

        // Dmem wait with a held redirect serviced on exit (dut_b times out and re-enters)
        for (int i = 0; i < 4; i++) begin
            tick(); v = red_in(1'b1); v.dmem_req = 1'b1; drive(v);
            exp_push(1'b0, "dmem_wait", O_DMEM, -1);
            exp_push(1'b1, "dmem_wait_tmo3", b_seq[i], -1);
        end
        tick(); v = red_in(1'b1); v.dmem_req = 1'b1; v.dmem_ready = 1'b1; drive(v);
        exp_both("dmem_exit_redir", O_RED0, -1);
        tick(); drive(IDLE); exp_both("dmem_redir_hold", O_RED1, -1);
        tick(); drive(IDLE); exp_both("dmem_done", O_NONE, 7);

        // Timeout pulse on the third wait cycle of dut_b
        for (int i = 0; i < 3; i++) begin
            tick(); v = IDLE; v.dmem_req = 1'b1; drive(v);
            exp_push(1'b0, "long_wait", O_DMEM, -1);
            exp_push(1'b1, (i == 2) ? "tmo_pulse" : "tmo_wait", (i == 2) ? O_TMO : O_DMEM, -1);
        end
        tick(); drive(IDLE); exp_both("tmo_after", O_NONE, 10);
        tick(); drive(IDLE); exp_push(1'b1, "tmo_err_once", O_NONE, -1);

        // Reset in the middle of a redirect sequence
        tick(); drive(red_in(1'b1)); exp_both("mid_redir", O_RED0, -1);
        tick(); rst = 1'b0; drive(IDLE); exp_both("rst_in_redir", O_RST, -1);
        tick(); drive(IDLE); exp_both("rst_hold", O_RST, -1);
        tick(); rst = 1'b1; drive(IDLE); exp_both("rst_rel_cnt", O_NONE, 0);
        tick(); drive(IDLE); exp_both("run_after_rst", O_NONE, -1);

        // Counter saturation on the 8-bit instance
        for (int i = 0; i < 260; i++) begin
            tick(); v = IDLE; v.imem_ready = 1'b0; drive(v);
        end
        tick(); drive(IDLE);
        exp_push(1'b0, "cnt_260", O_NONE, 260);
        exp_push(1'b1, "cnt_saturate", O_NONE, 255);

        tick(); tick();
        n_total++;
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end else begin
            n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
